regfile_wb_sched: RTL and testbench
===================================

# regfile_wb_sched

Write-back scheduler for the RV64IMFD integer and FP register files. It arbitrates round-robin among NREQ functional-unit result streams (ALU, MUL/DIV, FPU, LSU) for the single write port of each file, and registers the winning write. It also keeps a busy scoreboard of destinations with an outstanding write, which issue logic reads to stall on RAW/WAW hazards. It sits between the execute units and the register files.

## Interface
- NREQ, 4, number of write-back requesters (2..8)
- XLEN, 64, data width
- AW, 5, register index width
- clk  input  1  clock, all state on posedge
- rst  input  1  reset: one clock, asynchronous, active-high
- req_valid  input  NREQ  requester i has a result
- req_ready  output  NREQ  requester i result accepted this cycle
- req_addr  input  NREQ*AW  destination index, slice i = [i*AW +: AW]
- req_fp  input  NREQ  1 = FP file, 0 = integer file
- req_data  input  NREQ*XLEN  result data, slice i = [i*XLEN +: XLEN]
- wb_stall  input  1  regfile write port unavailable; no grant
- wr_en  output  1  write strobe to regfile
- wr_fp  output  1  selects the FP file
- wr_addr  output  AW  write index
- wr_data  output  XLEN  write data
- iss_valid  input  1  an instruction with a destination issues this cycle
- iss_fp  input  1  issued destination file
- iss_addr  input  AW  issued destination index
- busy_int  output  32  integer scoreboard, bit r = write pending to xr
- busy_fp  output  32  FP scoreboard, bit r = write pending to fr

## Operation
- Arbitration: combinational round-robin over req_valid, starting at pointer ptr.
  - At most one req_ready bit is high per cycle.
  - req_ready is 0 for all requesters while wb_stall=1 or rst=1.
- Handshake: a transfer occurs when req_valid[i] & req_ready[i].
  - A requester holds valid, addr, fp and data stable until it is accepted.
  - req_ready may depend on req_valid. req_valid must not depend on req_ready.
- ptr update:
  - On a transfer from requester g, ptr <= (g+1) mod NREQ.
  - With no transfer, ptr holds.
- Output register: on a transfer, the next cycle shows wr_en=1 with the captured wr_fp, wr_addr and wr_data. Otherwise wr_en=0. wr_fp, wr_addr and wr_data hold their last values when wr_en=0.
- x0 suppression: a transfer with req_fp=0 and addr=0 is accepted and advances ptr, but the next-cycle wr_en stays 0. f0 is a normal register.
- Scoreboard:
  - iss_valid sets the busy bit of (iss_fp, iss_addr).
  - A transfer clears the busy bit of (req_fp, req_addr) of the winner, in the same cycle as the transfer.
  - If set and clear target the same bit in one cycle, set wins.
  - Integer bit 0 always reads 0.
  - Clearing a bit that is not set is legal and has no effect.
- Reset values: req_ready=0, wr_en=0, wr_fp=0, wr_addr=0, wr_data=0, busy_int=0, busy_fp=0, ptr=0.
- Reset mid-operation: the pending output write is dropped, wr_en=0 immediately, and the scoreboard clears. Requesters must re-present their results after reset.

## Timing
- Acceptance to wr_en: 1 cycle.
- Back-to-back transfers sustain one write per cycle.
- busy bits are registered.
  - A bit set by iss_valid in cycle n is visible in cycle n+1.
  - A bit cleared by a transfer in cycle n reads 0 in cycle n+1, which is the same cycle the regfile write is issued.
  - Issue logic that needs the written value on that cycle must bypass from the wr_* outputs.
- wb_stall is sampled combinationally. A write already registered completes even if wb_stall rises in the same cycle; wb_stall blocks new grants only.
- No combinational path from iss_* to any output.

## Structure
- Package regfile_wb_pkg:
  - localparam XLEN=64, AW=5, NREQ=4.
  - typedef logic [AW-1:0] reg_idx_t.
  - typedef struct packed {logic fp; reg_idx_t addr; logic [XLEN-1:0] data;} wb_req_t.
- Sub-module rr_arbiter, parameter N:
  - Inputs: req[N], en, and ptr.
  - Outputs: one-hot gnt[N] and the binary index gnt_idx.
  - rr_arbiter is reused elsewhere.
- Top level holds ptr, the output register and the two 32-bit scoreboards.

## Test plan
- Reset then idle: assert rst for 3 cycles with req_valid=4'b1111 -> req_ready=0, wr_en=0 and busy_*=0 throughout; after release the first grant goes to requester 0.
- Fairness: hold req_valid=4'b1111 for 8 cycles with wb_stall=0 -> grant order 0,1,2,3,0,1,2,3; wr_en=1 on cycles 2-9; each wr_data equals the granted slice.
- x0 and f0: requester 1 writes int addr 0 = 64'hDEAD -> accepted, but no write. Requester 1 then writes fp addr 0 = 64'h3FF0_0000_0000_0000 -> wr_en=1, wr_fp=1, wr_addr=0.
- Stall: req_valid=4'b0100 and wb_stall=1 for 5 cycles -> req_ready=0 and ptr holds. When wb_stall drops, the grant goes to 2 and wr_en=1 on the next cycle.
- Scoreboard: issue int x5 -> busy_int[5]=1 next cycle. In a later cycle, issue x5 again while requester 3 writes x5 -> busy_int[5] stays 1. A further write to x5 -> busy_int[5]=0. Issue of x0 -> busy_int[0] stays 0.
- Reset mid-write: assert rst in the cycle after an accepted write to f7 -> wr_en falls asynchronously and busy_fp[7]=0.

Source files
------------

// File: rtl/regfile_wb_sched_pkg.sv
// Shared types for the register-file write-back scheduler.
// Ports: none (package only).
// Holds default widths and the write-back request record.
package regfile_wb_pkg;

  localparam int XLEN = 64;
  localparam int AW   = 5;
  localparam int NREQ = 4;

  typedef logic [AW-1:0] reg_idx_t;

  typedef struct packed {
    logic            fp;
    reg_idx_t        addr;
    logic [XLEN-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/regfile_wb_sched_rr_arbiter.sv
// Combinational round-robin arbiter: first request at or after ptr wins.
// Ports: req/en/ptr in; one-hot gnt and binary gnt_idx out. Zero latency.
// No grant at all while en=0; gnt only ever covers a requesting input.
module rr_arbiter
  import regfile_wb_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic                 en,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] gnt_idx
);

  localparam int IW = $clog2(N);

  // Scan from the farthest position back to ptr so the request closest to
  // ptr (in wrap-around order) is the last one written and therefore wins.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (en && req[(int'(ptr) + k) % N]) begin
        gnt                         = '0;
        gnt[(int'(ptr) + k) % N]    = 1'b1;
        gnt_idx                     = IW'((int'(ptr) + k) % N);
      end
    end
  end

endmodule

// File: rtl/regfile_wb_sched.sv
// Write-back scheduler: round-robin grant of NREQ result streams onto the
// single int/FP regfile write port, registered write, busy scoreboards.
// Ports: req_* (valid/ready per requester), wb_stall, wr_* (registered
// write, 1-cycle latency), iss_* (destination issue), busy_int/busy_fp.
module regfile_wb_sched
  import regfile_wb_pkg::*;
#(
  parameter int NREQ = regfile_wb_pkg::NREQ,
  parameter int XLEN = regfile_wb_pkg::XLEN,
  parameter int AW   = regfile_wb_pkg::AW
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*AW-1:0]   req_addr,
  input  logic [NREQ-1:0]      req_fp,
  input  logic [NREQ*XLEN-1:0] req_data,
  input  logic                 wb_stall,
  output logic                 wr_en,
  output logic                 wr_fp,
  output logic [AW-1:0]        wr_addr,
  output logic [XLEN-1:0]      wr_data,
  input  logic                 iss_valid,
  input  logic                 iss_fp,
  input  logic [AW-1:0]        iss_addr,
  output logic [31:0]          busy_int,
  output logic [31:0]          busy_fp
);

  localparam int PW = $clog2(NREQ);

  logic [PW-1:0]   ptr_q, ptr_d, gnt_idx;
  logic [NREQ-1:0] gnt;
  logic            xfer;
  logic            win_fp, win_x0;
  logic [AW-1:0]   win_addr;
  logic [XLEN-1:0] win_data;
  logic            wr_en_q, wr_fp_q;
  logic [AW-1:0]   wr_addr_q;
  logic [XLEN-1:0] wr_data_q;
  logic [31:0]     busy_int_q, busy_int_d, busy_fp_q, busy_fp_d;

  // Grants are masked during reset as well as stall so nothing is accepted
  // (and lost) while the state is being cleared.
  rr_arbiter #(.N(NREQ)) u_arb (
    .req     (req_valid),
    .en      (~wb_stall & ~rst),
    .ptr     (ptr_q),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  assign req_ready = gnt;
  assign xfer      = |gnt;
  assign win_fp    = req_fp[gnt_idx];
  assign win_addr  = req_addr[gnt_idx*AW +: AW];
  assign win_data  = req_data[gnt_idx*XLEN +: XLEN];
  // x0 writes are consumed but never reach the regfile.
  assign win_x0    = ~win_fp & (win_addr == '0);

  always_comb begin
    ptr_d = ptr_q;
    if (xfer) begin
      ptr_d = (gnt_idx == PW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end

  // Clear first, then set, so an issue to the same register in the cycle
  // its previous result retires keeps the bit busy.
  always_comb begin
    busy_int_d = busy_int_q;
    busy_fp_d  = busy_fp_q;
    if (xfer) begin
      if (win_fp) busy_fp_d[win_addr]  = 1'b0;
      else        busy_int_d[win_addr] = 1'b0;
    end
    if (iss_valid) begin
      if (iss_fp) busy_fp_d[iss_addr]  = 1'b1;
      else        busy_int_d[iss_addr] = 1'b1;
    end
    busy_int_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q      <= '0;
      wr_en_q    <= 1'b0;
      wr_fp_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      busy_int_q <= '0;
      busy_fp_q  <= '0;
    end else begin
      ptr_q      <= ptr_d;
      busy_int_q <= busy_int_d;
      busy_fp_q  <= busy_fp_d;
      wr_en_q    <= xfer & ~win_x0;
      // wr_fp/addr/data keep their last real write when no write is issued.
      if (xfer && !win_x0) begin
        wr_fp_q   <= win_fp;
        wr_addr_q <= win_addr;
        wr_data_q <= win_data;
      end
    end
  end

  assign wr_en    = wr_en_q;
  assign wr_fp    = wr_fp_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign busy_int = busy_int_q;
  assign busy_fp  = busy_fp_q;

endmodule

// File: tb/tb_regfile_wb_sched.sv
module tb_regfile_wb_sched;
  import regfile_wb_pkg::*;

  localparam int N = NREQ;

  logic              clk = 1'b0;
  logic              rst;
  logic [N-1:0]      req_valid, req_ready, req_fp;
  logic [N*AW-1:0]   req_addr;
  logic [N*XLEN-1:0] req_data;
  logic              wb_stall;
  logic              wr_en, wr_fp;
  logic [AW-1:0]     wr_addr;
  logic [XLEN-1:0]   wr_data;
  logic              iss_valid, iss_fp;
  logic [AW-1:0]     iss_addr;
  logic [31:0]       busy_int, busy_fp;

  always #5 clk = ~clk;

  regfile_wb_sched dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_fp(req_fp), .req_data(req_data), .wb_stall(wb_stall),
    .wr_en(wr_en), .wr_fp(wr_fp), .wr_addr(wr_addr), .wr_data(wr_data),
    .iss_valid(iss_valid), .iss_fp(iss_fp), .iss_addr(iss_addr),
    .busy_int(busy_int), .busy_fp(busy_fp)
  );

  // Requester side: one held result per requester until accepted.
  wb_req_t pend   [N];
  bit      pend_v [N];

  // Reference model state.
  int          m_ptr;
  int          m_gnt;
  bit          m_wr_en;
  wb_req_t     m_wr;
  logic [31:0] m_bi, m_bf;
  logic [N-1:0] obs_rdy;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_ptr   = 0;
    m_wr_en = 0;
    m_wr    = '0;
    m_bi    = '0;
    m_bf    = '0;
  endtask

  task automatic put(input int i, input bit fp, input int addr, input logic [63:0] d);
    pend[i].fp   = fp;
    pend[i].addr = AW'(addr);
    pend[i].data = d;
    pend_v[i]    = 1;
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      req_valid[i]               = pend_v[i];
      req_fp[i]                  = pend[i].fp;
      req_addr[i*AW +: AW]       = pend[i].addr;
      req_data[i*XLEN +: XLEN]   = pend[i].data;
    end
  endtask

  // One clock: check the combinational grant mid-cycle, advance the model at
  // the edge, then check the registered outputs just after it.
  task automatic step();
    logic [N-1:0] exp_rdy;
    wb_req_t w;
    drive();
    @(negedge clk);
    m_gnt = -1;
    if (!rst && !wb_stall)
      for (int k = 0; k < N; k++)
        if (m_gnt < 0 && pend_v[(m_ptr + k) % N]) m_gnt = (m_ptr + k) % N;
    exp_rdy = '0;
    if (m_gnt >= 0) exp_rdy[m_gnt] = 1'b1;
    obs_rdy = req_ready;
    chk("req_ready", req_ready, exp_rdy);
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      m_wr_en = 0;
      if (m_gnt >= 0) begin
        w = pend[m_gnt];
        pend_v[m_gnt] = 0;
        m_ptr = (m_gnt + 1) % N;
        if (w.fp) m_bf[w.addr] = 1'b0;
        else      m_bi[w.addr] = 1'b0;
        if (w.fp || w.addr != 0) begin
          m_wr_en = 1;
          m_wr    = w;
        end
      end
      if (iss_valid) begin
        if (iss_fp) m_bf[iss_addr] = 1'b1;
        else        m_bi[iss_addr] = 1'b1;
      end
      m_bi[0] = 1'b0;
    end
    #1;
    chk("wr_en", wr_en, m_wr_en);
    chk("wr_fp", wr_fp, m_wr.fp);
    chk("wr_addr", wr_addr, m_wr.addr);
    chk("wr_data", wr_data, m_wr.data);
    chk("busy_int", busy_int, m_bi);
    chk("busy_fp", busy_fp, m_bf);
  endtask

  initial begin
    rst = 1; wb_stall = 0; iss_valid = 0; iss_fp = 0; iss_addr = '0;
    for (int i = 0; i < N; i++) pend_v[i] = 0;
    model_reset();

    // Reset with every requester valid: nothing granted, all outputs clear.
    for (int i = 0; i < N; i++) put(i, 0, i + 8, {32'hA000_0000 | 32'(i), $urandom});
    for (int c = 0; c < 3; c++) step();
    rst = 0;

    // Fairness: all four continuously valid.
    for (int k = 0; k < 8; k++) begin
      for (int i = 0; i < N; i++)
        if (!pend_v[i]) put(i, i[0], i + 8, {32'hB000_0000 | 32'(k), $urandom});
      step();
      chk("rr_order", obs_rdy, 4'b0001 << (k % 4));
    end
    for (int i = 0; i < N; i++) pend_v[i] = 0;
    step();

    // x0 is swallowed, f0 is a real write.
    put(1, 0, 0, 64'hDEAD);
    step();
    chk("x0_accept", obs_rdy, 4'b0010);
    chk("x0_no_write", wr_en, 1'b0);
    put(1, 1, 0, 64'h3FF0_0000_0000_0000);
    step();
    chk("f0_write", {wr_en, wr_fp, 3'(wr_addr)}, 5'b11000);
    chk("f0_data", wr_data, 64'h3FF0_0000_0000_0000);

    // Stall blocks requester 2, then it wins on release.
    put(2, 0, 9, 64'h1234_5678_9ABC_DEF0);
    wb_stall = 1;
    for (int c = 0; c < 5; c++) begin
      step();
      chk("stall_rdy", obs_rdy, 4'b0000);
    end
    wb_stall = 0;
    step();
    chk("unstall_gnt", obs_rdy, 4'b0100);
    chk("unstall_wr", wr_en, 1'b1);

    // Scoreboard set / set-wins / clear / x0.
    iss_valid = 1; iss_fp = 0; iss_addr = 5'd5;
    step();
    chk("sb_set", busy_int[5], 1'b1);
    put(3, 0, 5, 64'h55);
    step();
    chk("sb_set_wins", busy_int[5], 1'b1);
    iss_valid = 0;
    put(3, 0, 5, 64'h56);
    step();
    chk("sb_clear", busy_int[5], 1'b0);
    iss_valid = 1; iss_addr = 5'd0;
    step();
    chk("sb_x0", busy_int[0], 1'b0);

    // Asynchronous reset right after an accepted f7 write.
    iss_fp = 1; iss_addr = 5'd7;
    put(0, 1, 7, 64'h7777);
    step();
    chk("pre_rst_busy", busy_fp[7], 1'b1);
    chk("pre_rst_wr", wr_en, 1'b1);
    iss_valid = 0;
    #2 rst = 1;
    #1;
    model_reset();
    chk("async_wr_en", wr_en, 1'b0);
    chk("async_busy_fp", busy_fp, 32'h0);
    chk("async_busy_int", busy_int, 32'h0);
    step();
    rst = 0;
    for (int i = 0; i < N; i++) pend_v[i] = 0;

    // Randomized traffic against the model.
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++)
        if (!pend_v[i] && $urandom_range(0, 1) == 1)
          put(i, 1'($urandom), $urandom_range(0, 31), {$urandom, $urandom});
      wb_stall  = ($urandom_range(0, 4) == 0);
      iss_valid = 1'($urandom);
      iss_fp    = 1'($urandom);
      iss_addr  = AW'($urandom_range(0, 31));
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
